game_tick_scheduler: RTL and testbench

Sequences the game datapath by generating the game tick strobe that advances floor/ceiling scroll and scoring. It runs only while a player is logged in. It starts on the shaped game button and halts on collision/game-over. Tick period shortens as play progresses (difficulty levels). It sits between the shaped button and authenticator outputs and the game controller's tick input, and drives the game-tick LED.

---
 rtl/game_tick_scheduler.sv | 129 ++++++++++++
 tb/tb_game_tick_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - game tick strobe generator with difficulty levels
// Optional pause support is enabled by defining GAME_TICK_PAUSE_EN.
module game_tick_scheduler #(
    parameter int CNT_W           = 26,
    parameter int BASE_PERIOD     = 50000000,
    parameter int STEP            = 5000000,
    parameter int MIN_PERIOD      = 5000000,
    parameter int TICKS_PER_LEVEL = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic             Start,
    input  logic             Stop,
`ifdef GAME_TICK_PAUSE_EN
    input  logic             Pause,
`endif
    output logic             Tick,
    output logic             Running,
    output logic [3:0]       Level,
    output logic [13:0]      TickCount,
    output logic [CNT_W-1:0] Period
);

    localparam int PW = CNT_W + 5;
    localparam logic [13:0] TC_MAX = 14'd9999;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
`ifdef GAME_TICK_PAUSE_EN
        , S_PAUSED
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      phase;
    logic [3:0]       next_level;
    logic [PW-1:0]    prod;
    logic [CNT_W-1:0] reload;
    logic             terminal;
    logic             level_up;
    logic             restart;

    // Wide unsigned compare avoids any wrap when level*STEP exceeds the base period.
    always_comb begin
        next_level = (Level == 4'd15) ? 4'd15 : Level + 4'd1;
        prod       = PW'(STEP) * PW'(next_level);
        if (prod + PW'(MIN_PERIOD) >= PW'(BASE_PERIOD))
            reload = CNT_W'(MIN_PERIOD);
        else
            reload = CNT_W'(PW'(BASE_PERIOD) - prod);
        terminal = (cnt == Period - CNT_W'(1));
        level_up = (phase == 16'(TICKS_PER_LEVEL - 1));
        restart  = Start && !Stop;
    end

    always_ff @(posedge Clk) begin
        if (Rst || !Enable) begin
            state     <= S_IDLE;
            Tick      <= 1'b0;
            Running   <= 1'b0;
            Level     <= 4'd0;
            TickCount <= 14'd0;
            Period    <= CNT_W'(BASE_PERIOD);
            cnt       <= '0;
            phase     <= 16'd0;
        end else begin
            Tick <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (restart) begin
                        state     <= S_RUN;
                        Running   <= 1'b1;
                        Level     <= 4'd0;
                        TickCount <= 14'd0;
                        Period    <= CNT_W'(BASE_PERIOD);
                        cnt       <= '0;
                        phase     <= 16'd0;
                    end
                end
                S_RUN: begin
                    if (Stop) begin
                        state   <= S_HALT;
                        Running <= 1'b0;
`ifdef GAME_TICK_PAUSE_EN
                    end else if (Pause) begin
                        state   <= S_PAUSED;
                        Running <= 1'b0;
`endif
                    end else if (terminal) begin
                        cnt  <= '0;
                        Tick <= 1'b1;
                        // Level progression stops once the score counter saturates.
                        if (TickCount != TC_MAX) begin
                            TickCount <= TickCount + 14'd1;
                            if (level_up) begin
                                phase  <= 16'd0;
                                Level  <= next_level;
                                Period <= reload;
                            end else begin
                                phase <= phase + 16'd1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef GAME_TICK_PAUSE_EN
                S_PAUSED: begin
                    if (Stop) begin
                        state <= S_HALT;
                    end else if (Pause) begin
                        state   <= S_RUN;
                        Running <= 1'b1;
                    end
                end
`endif
                default: begin
                    state   <= S_IDLE;
                    Running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb/tb_game_tick_scheduler.sv - scoreboard bench for game_tick_scheduler
module tb_game_tick_scheduler;

    localparam int CNT_W = 8;
    localparam int BASE  = 10;
    localparam int STEP  = 2;
    localparam int MINP  = 4;
    localparam int TPL   = 3;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             Enable = 1'b1;
    logic             Start = 1'b0;
    logic             Stop = 1'b0;
`ifdef GAME_TICK_PAUSE_EN
    logic             Pause = 1'b0;
`endif
    logic             Tick;
    logic             Running;
    logic [3:0]       Level;
    logic [13:0]      TickCount;
    logic [CNT_W-1:0] Period;

    game_tick_scheduler #(
        .CNT_W(CNT_W), .BASE_PERIOD(BASE), .STEP(STEP),
        .MIN_PERIOD(MINP), .TICKS_PER_LEVEL(TPL)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Start(Start), .Stop(Stop),
`ifdef GAME_TICK_PAUSE_EN
        .Pause(Pause),
`endif
        .Tick(Tick), .Running(Running), .Level(Level),
        .TickCount(TickCount), .Period(Period)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int cyc;
        int tc;
        int lvl;
        int per;
    } exp_t;

    exp_t q[$];
    exp_t e;
    exp_t got;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   m_run = 1'b0;
    int   m_tc = 0;
    int   m_lvl = 0;
    int   m_per = BASE;
    int   m_due = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: tracks absolute due times of ticks rather than a counter.
    always @(posedge Clk) begin
        cyc++;
        if (Rst || !Enable) begin
            m_run = 1'b0; m_tc = 0; m_lvl = 0; m_per = BASE;
        end else if (m_run) begin
            if (Stop) begin
                m_run = 1'b0;
            end else if (cyc == m_due) begin
                if (m_tc < 9999) begin
                    m_tc++;
                    if (m_tc % TPL == 0) begin
                        m_lvl = (m_lvl < 15) ? m_lvl + 1 : 15;
                        m_per = BASE - m_lvl * STEP;
                        if (m_per < MINP) m_per = MINP;
                    end
                end
                e.cyc = cyc; e.tc = m_tc; e.lvl = m_lvl; e.per = m_per;
                q.push_back(e);
                m_due = cyc + m_per;
            end
        end else if (Start && !Stop) begin
            m_run = 1'b1; m_tc = 0; m_lvl = 0; m_per = BASE; m_due = cyc + BASE;
        end
    end

    // Monitor: samples on the falling edge and retires expected ticks.
    always @(negedge Clk) begin
        if (cyc >= 1) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missed_tick", 0, 1);
                void'(q.pop_front());
            end
            chk("tick", int'(Tick), (q.size() > 0 && q[0].cyc == cyc) ? 1 : 0);
            if (Tick && q.size() > 0 && q[0].cyc == cyc) begin
                got = q.pop_front();
                chk("tick_count_at_tick", int'(TickCount), got.tc);
                chk("level_at_tick", int'(Level), got.lvl);
                chk("period_at_tick", int'(Period), got.per);
            end
            chk("running", int'(Running), int'(m_run));
            chk("level", int'(Level), m_lvl);
            chk("tick_count", int'(TickCount), m_tc);
            chk("period", int'(Period), m_per);
        end
    end

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic stop_at_due();
        int n = 0;
        while (!(m_run && cyc + 1 == m_due) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 200) chk("stop_wait_timeout", n, 0);
        Stop = 1'b1;
        @(negedge Clk);
        Stop = 1'b0;
    endtask

    initial begin
        int r;
        int n;
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Rst   = 1'b0;
        repeat (5) @(negedge Clk);

        pulse_start();
        repeat (260) @(negedge Clk);

        Enable = 1'b0;
        @(negedge Clk);
        Enable = 1'b1;
        pulse_start();
        n = 0;
        while (m_tc != 1 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 100) chk("first_tick_timeout", n, 0);
        stop_at_due();
        repeat (20) @(negedge Clk);
        pulse_start();
        repeat (40) @(negedge Clk);

        Enable = 1'b0;
        @(negedge Clk);
        Enable = 1'b1;
        Start = 1'b1;
        Stop  = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Stop  = 1'b0;
        repeat (15) @(negedge Clk);
        pulse_start();
        repeat (25) @(negedge Clk);
        Enable = 1'b0;
        repeat (15) @(negedge Clk);
        Enable = 1'b1;

        repeat (4000) begin
            r = int'($urandom_range(0, 199));
            Start  = (r < 6);
            Stop   = (r >= 4 && r < 8);
            Enable = (r != 199);
            Rst    = (r == 198);
            if (r == 197 && m_run) begin
                Start = 1'b0; Stop = 1'b0; Enable = 1'b1; Rst = 1'b0;
                stop_at_due();
            end else begin
                @(negedge Clk);
            end
        end
        Start = 1'b0; Stop = 1'b0; Enable = 1'b1; Rst = 1'b0;
        repeat (30) @(negedge Clk);
        Enable = 1'b0;
        repeat (3) @(negedge Clk);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
